// File: rtl/omsp_sm_ctrl_ng.sv
// omsp_sm_ctrl_ng: Sancus SM control; allocates IDs and slots via IDLE/SCAN/COMMIT/DONE handshake, tracks cur/prev module ID, aggregates violations
module omsp_sm_ctrl_ng #(
  parameter int NB_SMS = 4,
  parameter int ID_W   = 16,
  parameter int IRQ_W  = 4
) (
  input  logic                     mclk,
  input  logic                     puc_rst,
  input  logic                     update_req,
  input  logic                     enable_req,
  input  logic                     handling_irq,
  input  logic [IRQ_W-1:0]         irq_num,
  input  logic [NB_SMS-1:0]        sm_enabled,
  input  logic [NB_SMS-1:0]        sm_executing,
  input  logic [NB_SMS*ID_W-1:0]   sm_id,
  input  logic [NB_SMS-1:0]        sm_violation,
  output logic [NB_SMS-1:0]        sm_update,
  output logic [NB_SMS-1:0]        sm_check,
  output logic [ID_W-1:0]          next_id,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               status,
  output logic                     violation,
  output logic [ID_W-1:0]          cur_id,
  output logic [ID_W-1:0]          prev_id,
  output logic                     enter_sm,
  output logic                     exit_sm
);
  localparam logic [ID_W-1:0] IRQ_BASE = {ID_W{1'b1}} << IRQ_W;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, DONE} state_t;
  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [NB_SMS-1:0] target_q, target_d, free;
  logic [1:0]        status_q, status_d;
  logic [ID_W-1:0]   next_id_q, next_id_d, last_id_q, last_id_d, prev_id_q, prev_id_d, exec_id;
  logic              found, hit;
  always_comb begin
    free = '0;
    found = 1'b0;
    for (int i = 0; i < NB_SMS; i++)
      if (!sm_enabled[i] && !found) begin
        free[i] = 1'b1;
        found = 1'b1;
      end
  end
  always_comb begin
    exec_id = '0;
    hit = 1'b0;
    for (int i = 0; i < NB_SMS; i++)
      if (sm_executing[i] && !hit) begin
        exec_id = sm_id[i*ID_W +: ID_W];
        hit = 1'b1;
      end
  end
  assign cur_id    = handling_irq ? IRQ_BASE + ID_W'(irq_num) : exec_id;
  // x & (x-1) is nonzero exactly when more than one bit of x is set
  assign violation = |sm_violation | |(sm_executing & (sm_executing - NB_SMS'(1)));
  assign enter_sm  = (cur_id != last_id_q) && (cur_id != '0);
  assign exit_sm   = (cur_id != last_id_q) && (last_id_q != '0);
  assign last_id_d = cur_id;
  assign prev_id_d = (cur_id != last_id_q) ? last_id_q : prev_id_q;
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    target_d  = target_q;
    status_d  = status_q;
    next_id_d = next_id_q;
    sm_update = '0;
    sm_check  = '0;
    case (state_q)
      IDLE: if (update_req) begin
        mode_d  = enable_req;
        state_d = SCAN;
      end
      SCAN: begin
        target_d = mode_q ? free : '1;
        status_d = !mode_q ? 2'd0 : !found ? 2'd1 : (next_id_q == IRQ_BASE) ? 2'd2 : 2'd0;
        state_d  = (status_d == 2'd0) ? COMMIT : DONE;
      end
      COMMIT: begin
        sm_update = target_q;
        sm_check  = mode_q ? sm_enabled & ~target_q : '0;
        // the array itself drops an update whose check fails; here only the ID is withheld
        status_d  = (mode_q && |sm_violation) ? 2'd3 : 2'd0;
        next_id_d = (mode_q && !(|sm_violation)) ? next_id_q + ID_W'(1) : next_id_q;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge mclk or posedge puc_rst)
    if (puc_rst) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      target_q  <= '0;
      status_q  <= 2'd0;
      next_id_q <= ID_W'(1);
      last_id_q <= '0;
      prev_id_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      target_q  <= target_d;
      status_q  <= status_d;
      next_id_q <= next_id_d;
      last_id_q <= last_id_d;
      prev_id_q <= prev_id_d;
    end
  assign next_id = next_id_q;
  assign prev_id = prev_id_q;
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign status  = status_q;
endmodule

// File: tb/tb_omsp_sm_ctrl_ng.sv
// tb_omsp_sm_ctrl_ng: randomized self-checking bench for omsp_sm_ctrl_ng against a transaction-level model
module tb_omsp_sm_ctrl_ng;
  localparam int NB = 4, IW = 8, QW = 4;
  localparam logic [IW-1:0] IRQ_BASE = 8'hF0;
  logic mclk, puc_rst, update_req, enable_req, handling_irq;
  logic [QW-1:0] irq_num;
  logic [NB-1:0] sm_enabled, sm_executing, sm_violation, sm_update, sm_check;
  logic [NB*IW-1:0] sm_id;
  logic [IW-1:0] next_id, cur_id, prev_id;
  logic busy, done, violation, enter_sm, exit_sm;
  logic [1:0] status;
  int n_chk, n_err;
  logic [IW-1:0] m_next, m_last, m_prev;
  omsp_sm_ctrl_ng #(.NB_SMS(NB), .ID_W(IW), .IRQ_W(QW)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .update_req(update_req), .enable_req(enable_req),
    .handling_irq(handling_irq), .irq_num(irq_num), .sm_enabled(sm_enabled),
    .sm_executing(sm_executing), .sm_id(sm_id), .sm_violation(sm_violation),
    .sm_update(sm_update), .sm_check(sm_check), .next_id(next_id), .busy(busy),
    .done(done), .status(status), .violation(violation), .cur_id(cur_id),
    .prev_id(prev_id), .enter_sm(enter_sm), .exit_sm(exit_sm));
  initial mclk = 1'b0;
  always #5 mclk = ~mclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge mclk);
    #1;
  endtask
  task automatic txn(input logic en, input logic [NB-1:0] ena, input logic [NB-1:0] vio);
    logic [NB-1:0] tgt;
    logic [1:0] st;
    int fr;
    fr = -1;
    for (int i = NB - 1; i >= 0; i--) if (!ena[i]) fr = i;
    tgt = !en ? '1 : (fr < 0) ? '0 : NB'(1 << fr);
    st = !en ? 2'd0 : (fr < 0) ? 2'd1 : (m_next == IRQ_BASE) ? 2'd2 : (|vio) ? 2'd3 : 2'd0;
    sm_enabled = ena; enable_req = en; update_req = 1'b1; sm_violation = '0;
    #1 chk("idle_busy", busy, 0);
    tick;
    update_req = 1'($urandom_range(0, 1)); enable_req = 1'($urandom_range(0, 1));
    chk("scan_busy", busy, 1);
    chk("scan_done", done, 0);
    chk("scan_upd", sm_update, 0);
    tick;
    update_req = 1'($urandom_range(0, 1));
    if (st == 2'd1 || st == 2'd2) begin
      chk("err_done", done, 1);
      chk("err_status", status, st);
      chk("err_upd", sm_update, 0);
    end else begin
      sm_violation = vio;
      #1;
      chk("commit_done", done, 0);
      chk("commit_upd", sm_update, tgt);
      chk("commit_check", sm_check, en ? ena & ~tgt : '0);
      chk("commit_viol", violation, |vio);
      tick;
      sm_violation = '0;
      update_req = 1'($urandom_range(0, 1));
      chk("done", done, 1);
      chk("status", status, st);
      chk("done_busy", busy, 1);
      chk("done_upd", sm_update, 0);
      if (en && st == 2'd0) m_next++;
    end
    chk("next_id", next_id, m_next);
    tick;
    update_req = 1'b0;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
  endtask
  task automatic idstep(input logic [NB-1:0] ex, input logic [NB*IW-1:0] ids, input logic hirq, input logic [QW-1:0] irq);
    logic [IW-1:0] e;
    sm_executing = ex; sm_id = ids; handling_irq = hirq; irq_num = irq;
    e = '0;
    if (hirq) e = IRQ_BASE + IW'(irq);
    else for (int i = NB - 1; i >= 0; i--) if (ex[i]) e = ids[i*IW +: IW];
    #1;
    chk("cur_id", cur_id, e);
    chk("enter_sm", enter_sm, (e != m_last) && (e != 0));
    chk("exit_sm", exit_sm, (e != m_last) && (m_last != 0));
    chk("prev_id", prev_id, m_prev);
    chk("violation", violation, $countones(ex) > 1);
    tick;
    if (e != m_last) begin m_prev = m_last; m_last = e; end
  endtask
  initial begin
    n_chk = 0; n_err = 0;
    puc_rst = 1'b1; update_req = 0; enable_req = 0; handling_irq = 0; irq_num = 0;
    sm_enabled = 0; sm_executing = 0; sm_id = 0; sm_violation = 0;
    m_next = 1; m_last = 0; m_prev = 0;
    #1;
    chk("rst_next_id", next_id, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_upd", sm_update, 0);
    chk("rst_check", sm_check, 0);
    chk("rst_prev", prev_id, 0);
    chk("rst_enter", enter_sm, 0);
    chk("rst_exit", exit_sm, 0);
    tick;
    puc_rst = 1'b0;
    tick;
    txn(1, 4'b0000, 4'b0000);
    txn(1, 4'b1111, 4'b0000);
    txn(1, 4'b1110, 4'b0010);
    txn(0, 4'b0101, 4'b0000);
    txn(1, 4'b0011, 4'b0000);
    sm_enabled = 0; enable_req = 1; update_req = 1;
    tick;
    update_req = 0;
    tick;
    puc_rst = 1'b1;
    #1;
    m_next = 1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_next", next_id, m_next);
    tick;
    puc_rst = 1'b0;
    tick;
    chk("abort_nodone", done, 0);
    idstep(4'b0100, 32'h0005_0000, 0, 0);
    idstep(4'b0100, 32'h0005_0000, 0, 0);
    idstep(4'b0100, 32'h0005_0000, 1, 3);
    idstep(4'b0000, 32'h0005_0000, 1, 3);
    idstep(4'b0110, 32'h0005_0900, 0, 0);
    for (int k = 0; k < 150; k++)
      idstep(NB'($urandom), {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))},
             $urandom_range(0, 7) == 0, QW'($urandom));
    idstep(0, 0, 0, 0);
    for (int k = 0; k < 700; k++)
      txn($urandom_range(0, 3) != 0, ($urandom_range(0, 15) == 0) ? 4'hF : NB'($urandom),
          ($urandom_range(0, 7) == 0) ? NB'($urandom_range(1, 15)) : '0);
    chk("exhausted", next_id, IRQ_BASE);
    txn(1, 4'b0000, 4'b0000);
    txn(1, 4'b1111, 4'b0000);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
